// File: rtl/conv_window_3x3_if.sv
// Stream bundle between a raster pixel source and the 3x3 window generator.
// Optional end-of-frame flag present only when WINDOW_EOF_EN is defined.
interface conv_window_3x3_if #(
    parameter int WIDTH = 8
);
    logic                 input_vld;
    logic [WIDTH-1:0]     din;
    logic [9*WIDTH-1:0]   win;
    logic                 win_vld;
    logic                 busy;
`ifdef WINDOW_EOF_EN
    logic                 win_last;
`endif

    modport master (
        output input_vld, din,
`ifdef WINDOW_EOF_EN
        input  win_last,
`endif
        input  win, win_vld, busy
    );

    modport slave (
        input  input_vld, din,
`ifdef WINDOW_EOF_EN
        output win_last,
`endif
        output win, win_vld, busy
    );
endinterface

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 valid-convolution window generator with two IMG_W-deep row lines.
// Define WINDOW_EOF_EN to add the win_last end-of-frame flag.
module conv_window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic           clk,
    input  logic           rst,
    conv_window_3x3_if.slave io
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [WIDTH-1:0]   line1_q [IMG_W];
    logic [WIDTH-1:0]   line2_q [IMG_W];
    logic [WIDTH-1:0]   tap_q [3][3];
    logic [WIDTH-1:0]   tap_d [3][3];
    logic [9*WIDTH-1:0] win_q, win_d, flat_d;
    logic               win_vld_q;
    logic               accept, last_pix, win_ok;

    assign accept   = rst && io.input_vld;
    assign last_pix = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign win_ok   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FILL;
            FILL:    if (accept && row_d >= RW'(2)) state_d = RUN;
            RUN:     if (last_pix) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Internal taps shift on every beat; the visible window only updates on
    // in-image positions so win stays frozen between strobes.
    always_comb begin
        tap_d = tap_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                tap_d[i][0] = tap_q[i][1];
                tap_d[i][1] = tap_q[i][2];
            end
            tap_d[0][2] = line2_q[IMG_W-1];
            tap_d[1][2] = line1_q[IMG_W-1];
            tap_d[2][2] = io.din;
        end
        flat_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                flat_d[(3*i+j)*WIDTH +: WIDTH] = tap_d[i][j];
            end
        end
        win_d = win_ok ? flat_d : win_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    tap_q[i][j] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            win_vld_q <= win_ok;
            tap_q     <= tap_d;
        end
    end

    // Line 1 delays din by one row; line 2 delays line 1 by another row.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                line1_q[i] <= '0;
                line2_q[i] <= '0;
            end
        end else if (accept) begin
            line1_q[0] <= io.din;
            line2_q[0] <= line1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                line1_q[i] <= line1_q[i-1];
                line2_q[i] <= line2_q[i-1];
            end
        end
    end

`ifdef WINDOW_EOF_EN
    logic win_last_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_last_q <= 1'b0;
        end else begin
            win_last_q <= last_pix;
        end
    end

    assign io.win_last = win_last_q;
`endif

    assign io.win     = win_q;
    assign io.win_vld = win_vld_q;
    // A beat being accepted counts as frame-in-progress, so busy does not
    // dip between back-to-back frames.
    assign io.busy    = (state_q != IDLE) || accept;
endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed bench for conv_window_3x3: a 5x4 instance for frame/gap/reset
// scenarios and a default 28x28 instance for the full-frame window count.
module tb_conv_window_3x3;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_window_3x3_if #(.WIDTH(W)) s_if ();
    conv_window_3x3_if #(.WIDTH(W)) b_if ();

    conv_window_3x3 #(.WIDTH(W), .IMG_W(5), .IMG_H(4)) u_small (
        .clk(clk), .rst(rst), .io(s_if.slave)
    );
    conv_window_3x3 #(.WIDTH(W)) u_big (
        .clk(clk), .rst(rst), .io(b_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Element offsets of a 5-wide window, and top-left pixel of the 6 windows
    localparam int OFS [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    localparam int TL  [6] = '{0, 1, 2, 5, 6, 7};
    localparam int BF  [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    localparam int BL  [9] = '{213, 214, 215, 241, 242, 243, 13, 14, 15};

    function automatic logic [9*W-1:0] exp_win(input int base, input int tl);
        logic [9*W-1:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*W +: W] = W'(base + tl + OFS[k]);
        return r;
    endfunction

    // Small-instance monitor
    logic           acc_s = 1'b0;
    logic [9*W-1:0] s_q [$];
    logic [9*W-1:0] s_prev;
    int             s_hold_viol = 0;
    int             s_gap_viol  = 0;
`ifdef WINDOW_EOF_EN
    logic           s_last_q [$];
    int             s_last_viol = 0;
`endif

    always @(posedge clk) acc_s <= rst && s_if.input_vld;

    always @(negedge clk) begin
        if (s_if.win_vld) begin
            s_q.push_back(s_if.win);
            if (!acc_s) s_gap_viol++;
        end else if (s_if.win !== s_prev) begin
            s_hold_viol++;
        end
        s_prev = s_if.win;
`ifdef WINDOW_EOF_EN
        if (s_if.win_vld) s_last_q.push_back(s_if.win_last);
        else if (s_if.win_last !== 1'b0) s_last_viol++;
`endif
    end

    // Big-instance monitor
    int             b_strobes = 0;
    logic [9*W-1:0] b_first, b_last;

    always @(negedge clk) begin
        if (b_if.win_vld) begin
            if (b_strobes == 0) b_first = b_if.win;
            b_last = b_if.win;
            b_strobes++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic s_drive(input logic [W-1:0] v);
        s_if.input_vld = 1'b1;
        s_if.din       = v;
        @(posedge clk); #1;
    endtask

    task automatic s_idle();
        s_if.input_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_if.input_vld = 1'b0;
        s_if.din       = '0;
        b_if.input_vld = 1'b0;
        b_if.din       = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        s_q.delete();
        s_hold_viol = 0;
        s_gap_viol  = 0;
        b_strobes   = 0;
`ifdef WINDOW_EOF_EN
        s_last_q.delete();
        s_last_viol = 0;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (s_if.win !== '0) begin
            n_fail++; $display("FAIL reset_win: got %h want 0", s_if.win);
        end
        n_checks++;
        if (s_if.win_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_win_vld: got %b want 0", s_if.win_vld);
        end
        n_checks++;
        if (s_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", s_if.busy);
        end
        n_checks++;
        if (b_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_big_busy: got %b want 0", b_if.busy);
        end
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int p = 0; p < 20; p++) begin
            s_drive(W'(p));
            n_checks++;
            if (s_if.win_vld !== ((p / 5 >= 2) && (p % 5 >= 2))) begin
                n_fail++; $display("FAIL basic_vld p=%0d: got %b", p, s_if.win_vld);
            end
        end
        s_idle();
        n_checks++;
        if (s_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_end: got %b want 0", s_if.busy);
        end
        s_idle();
        n_checks++;
        if (s_q.size() != 6) begin
            n_fail++; $display("FAIL basic_count: got %0d want 6", s_q.size());
        end
        for (int i = 0; i < 6 && i < s_q.size(); i++) begin
            n_checks++;
            if (s_q[i] !== exp_win(0, TL[i])) begin
                n_fail++; $display("FAIL basic_win%0d: got %h want %h", i, s_q[i], exp_win(0, TL[i]));
            end
        end
        n_checks++;
        if (s_hold_viol != 0) begin
            n_fail++; $display("FAIL basic_hold: got %0d changes want 0", s_hold_viol);
        end
    endtask

    task automatic test_gaps();
        int p = 0;
        int cycles = 0;
        do_reset();
        while (p < 20 && cycles < 400) begin
            if ($urandom_range(0, 1) == 1) begin
                s_drive(W'(p));
                p++;
            end else begin
                s_idle();
            end
            cycles++;
        end
        s_idle();
        s_idle();
        n_checks++;
        if (p != 20) begin
            n_fail++; $display("FAIL gaps_budget: got %0d pixels want 20", p);
        end
        n_checks++;
        if (s_q.size() != 6) begin
            n_fail++; $display("FAIL gaps_count: got %0d want 6", s_q.size());
        end
        for (int i = 0; i < 6 && i < s_q.size(); i++) begin
            n_checks++;
            if (s_q[i] !== exp_win(0, TL[i])) begin
                n_fail++; $display("FAIL gaps_win%0d: got %h want %h", i, s_q[i], exp_win(0, TL[i]));
            end
        end
        n_checks++;
        if (s_hold_viol != 0) begin
            n_fail++; $display("FAIL gaps_hold: got %0d changes want 0", s_hold_viol);
        end
        n_checks++;
        if (s_gap_viol != 0) begin
            n_fail++; $display("FAIL gaps_strobe_in_gap: got %0d want 0", s_gap_viol);
        end
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        do_reset();
        for (int p = 0; p < 14; p++) s_drive(W'(p));
        s_idle();
        n_checks++;
        if (s_q.size() != 2) begin
            n_fail++; $display("FAIL mid_pre_count: got %0d want 2", s_q.size());
        end
        do_reset();
        n_checks++;
        if (s_if.win !== '0 || s_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_state: got win=%h busy=%b want 0/0", s_if.win, s_if.busy);
        end
        for (int p = 0; p < 20; p++) s_drive(W'(100 + p));
        s_idle();
        s_idle();
        n_checks++;
        if (s_q.size() != 6) begin
            n_fail++; $display("FAIL mid_count: got %0d want 6", s_q.size());
        end
        foreach (s_q[i]) begin
            for (int k = 0; k < 9; k++) begin
                if (s_q[i][k*W +: W] < W'(100)) bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_stale: got %0d stale elements want 0", bad);
        end
        for (int i = 0; i < 6 && i < s_q.size(); i++) begin
            n_checks++;
            if (s_q[i] !== exp_win(100, TL[i])) begin
                n_fail++; $display("FAIL mid_win%0d: got %h want %h", i, s_q[i], exp_win(100, TL[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 20; p++) begin
                s_drive(W'(20 * f + p));
                n_checks++;
                if (s_if.busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_busy f=%0d p=%0d: got %b want 1", f, p, s_if.busy);
                end
                n_checks++;
                if (s_if.win_vld !== ((p / 5 >= 2) && (p % 5 >= 2))) begin
                    n_fail++; $display("FAIL b2b_vld f=%0d p=%0d: got %b", f, p, s_if.win_vld);
                end
            end
        end
        s_idle();
        s_idle();
        n_checks++;
        if (s_q.size() != 12) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 12", s_q.size());
        end
        for (int i = 0; i < 6 && i + 6 < s_q.size(); i++) begin
            n_checks++;
            if (s_q[6+i] !== exp_win(20, TL[i])) begin
                n_fail++; $display("FAIL b2b_win%0d: got %h want %h", 6 + i, s_q[6+i], exp_win(20, TL[i]));
            end
        end
    endtask

    task automatic test_full_frame();
        int busy_low = 0;
        logic [9*W-1:0] ef, el;
        do_reset();
        for (int i = 0; i < 784; i++) begin
            b_if.input_vld = 1'b1;
            b_if.din       = W'(i % 256);
            @(posedge clk); #1;
            if (b_if.busy !== 1'b1) busy_low++;
        end
        b_if.input_vld = 1'b0;
        #1;
        n_checks++;
        if (busy_low != 0) begin
            n_fail++; $display("FAIL full_busy_during: got %0d low cycles want 0", busy_low);
        end
        n_checks++;
        if (b_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL full_busy_after: got %b want 0", b_if.busy);
        end
        @(posedge clk); #1;
        ef = '0;
        el = '0;
        for (int k = 0; k < 9; k++) begin
            ef[k*W +: W] = W'(BF[k]);
            el[k*W +: W] = W'(BL[k]);
        end
        n_checks++;
        if (b_strobes != 676) begin
            n_fail++; $display("FAIL full_count: got %0d want 676", b_strobes);
        end
        n_checks++;
        if (b_first !== ef) begin
            n_fail++; $display("FAIL full_first: got %h want %h", b_first, ef);
        end
        n_checks++;
        if (b_last !== el) begin
            n_fail++; $display("FAIL full_last: got %h want %h", b_last, el);
        end
    endtask

`ifdef WINDOW_EOF_EN
    task automatic test_eof();
        do_reset();
        for (int p = 0; p < 20; p++) s_drive(W'(p));
        s_idle();
        s_idle();
        n_checks++;
        if (s_last_q.size() != 6) begin
            n_fail++; $display("FAIL eof_count: got %0d want 6", s_last_q.size());
        end
        for (int i = 0; i < s_last_q.size(); i++) begin
            n_checks++;
            if (s_last_q[i] !== (i == 5)) begin
                n_fail++; $display("FAIL eof_last%0d: got %b want %b", i, s_last_q[i], (i == 5));
            end
        end
        n_checks++;
        if (s_last_viol != 0) begin
            n_fail++; $display("FAIL eof_spurious: got %0d want 0", s_last_viol);
        end
    endtask
`endif

    initial begin
        s_if.input_vld = 1'b0;
        s_if.din       = '0;
        b_if.input_vld = 1'b0;
        b_if.din       = '0;
        test_reset();
        test_basic_frame();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        test_full_frame();
`ifdef WINDOW_EOF_EN
        test_eof();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
